// File: rtl/d_debounce.sv
// d_debounce: synchronizes a raw asynchronous input and filters it with a settle counter FSM.
// Optional rise/fall edge pulses are built only when D_DEBOUNCE_EDGE_PULSE_EN is defined.
module d_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int SETTLE_CYCLES = 1000,
    parameter int CNT_W         = 16
) (
    input  logic Clk,
    input  logic reset,
    input  logic D_raw,
    output logic D,
    output logic D_bar,
    output logic busy,
    output logic rise,
    output logic fall
);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   d_q, d_d;
    logic                   d_bar_q;
    logic                   busy_q, busy_d;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], D_raw};
        end
    end

    // Only the last synchronizer stage is trusted; earlier stages may be metastable.
    assign s = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            STABLE_LO: begin
                if (s) begin
                    state_d = WAIT_HI;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!s) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            STABLE_HI: begin
                if (!s) begin
                    state_d = WAIT_LO;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (s) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
        // Outputs are derived from the next state so they register on the same edge as the state.
        d_d    = (state_d == STABLE_HI) || (state_d == WAIT_LO);
        busy_d = (state_d == WAIT_HI) || (state_d == WAIT_LO);
    end

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            state_q <= STABLE_LO;
            cnt_q   <= '0;
            d_q     <= 1'b0;
            d_bar_q <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_q     <= d_d;
            d_bar_q <= ~d_d;
            busy_q  <= busy_d;
        end
    end

    assign D     = d_q;
    assign D_bar = d_bar_q;
    assign busy  = busy_q;

`ifdef D_DEBOUNCE_EDGE_PULSE_EN
    logic rise_q, fall_q;

    always_ff @(posedge Clk or posedge reset) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (state_q == WAIT_HI) && (state_d == STABLE_HI);
            fall_q <= (state_q == WAIT_LO) && (state_d == STABLE_LO);
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: tb/tb_d_debounce.sv
// tb_d_debounce: directed per-cycle vector table plus hand-written async reset and requalification sequences.
// Edge-pulse expectations follow whether D_DEBOUNCE_EDGE_PULSE_EN is defined for the build.
module tb_d_debounce;

    typedef struct packed {
        logic raw;
        logic rst;
        logic expD;
        logic expBusy;
        logic expRise;
        logic expFall;
    } vec_t;

`ifdef D_DEBOUNCE_EDGE_PULSE_EN
    localparam logic EDGE_EN = 1'b1;
`else
    localparam logic EDGE_EN = 1'b0;
`endif

    logic Clk;
    logic reset;
    logic D_raw;
    logic D, D_bar, busy, rise, fall;
    logic ffQ;

    int checks;
    int errors;
    vec_t vecs[$];

    d_debounce #(
        .SYNC_STAGES  (2),
        .SETTLE_CYCLES(4),
        .CNT_W        (16)
    ) dut (
        .Clk  (Clk),
        .reset(reset),
        .D_raw(D_raw),
        .D    (D),
        .D_bar(D_bar),
        .busy (busy),
        .rise (rise),
        .fall (fall)
    );

    // Downstream flop standing in for d_ff, fed by the debounced level.
    always_ff @(posedge Clk or posedge reset) begin
        if (reset) ffQ <= 1'b0;
        else       ffQ <= D;
    end

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic addVec(input logic raw, input logic rst, input logic d,
                          input logic b, input logic r, input logic f);
        vecs.push_back({raw, rst, d, b, r, f});
    endtask

    task automatic applyStimulus(input logic raw, input logic rst);
        D_raw = raw;
        reset = rst;
        @(posedge Clk);
        #1;
    endtask

    initial begin
        logic prevD;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        D_raw  = 1'b1;

        // Reset window with input already high.
        addVec(1, 1, 0, 0, 0, 0);
        addVec(1, 1, 0, 0, 0, 0);
        // Release with input held high: accepted on the 6th edge.
        addVec(1, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(1, 0, 1, 0, 1, 0);
        addVec(1, 0, 1, 0, 0, 0);
        addVec(1, 0, 1, 0, 0, 0);
        // Qualified fall back to 0.
        addVec(0, 0, 1, 0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0);
        addVec(0, 0, 1, 1, 0, 0);
        addVec(0, 0, 1, 1, 0, 0);
        addVec(0, 0, 1, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 1);
        addVec(0, 0, 0, 0, 0, 0);
        // Three-cycle pulse: rejected.
        addVec(1, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);
        // Toggle every cycle for 8 cycles, then hold high.
        addVec(1, 0, 0, 0, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(1, 0, 0, 0, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(1, 0, 0, 1, 0, 0);
        addVec(1, 0, 1, 0, 1, 0);
        addVec(1, 0, 1, 0, 0, 0);

        prevD = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i].raw, vecs[i].rst);
            checkOutput($sformatf("row%0d.D", i), D, vecs[i].expD);
            checkOutput($sformatf("row%0d.D_bar", i), D_bar, ~vecs[i].expD);
            checkOutput($sformatf("row%0d.busy", i), busy, vecs[i].expBusy);
            checkOutput($sformatf("row%0d.rise", i), rise, vecs[i].expRise & EDGE_EN);
            checkOutput($sformatf("row%0d.fall", i), fall, vecs[i].expFall & EDGE_EN);
            checkOutput($sformatf("row%0d.ffQ", i), ffQ, vecs[i].rst ? 1'b0 : prevD);
            prevD = vecs[i].expD;
        end

        // Start a fall qualification, then hit reset between edges mid-WAIT.
        for (int k = 1; k <= 4; k++) applyStimulus(1'b0, 1'b0);
        checkOutput("midwait.busy", busy, 1'b1);
        checkOutput("midwait.D", D, 1'b1);
        #3;
        reset = 1'b1;
        #1;
        checkOutput("asyncrst.D", D, 1'b0);
        checkOutput("asyncrst.D_bar", D_bar, 1'b1);
        checkOutput("asyncrst.busy", busy, 1'b0);
        checkOutput("asyncrst.fall", fall, 1'b0);
        D_raw = 1'b1;
        @(posedge Clk);
        #1;
        checkOutput("rsthold.D", D, 1'b0);

        // Input held high across reset release must be fully requalified.
        reset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            applyStimulus(1'b1, 1'b0);
            checkOutput($sformatf("requal%0d.D", k), D, (k >= 6) ? 1'b1 : 1'b0);
            checkOutput($sformatf("requal%0d.busy", k), busy, (k >= 3 && k <= 5) ? 1'b1 : 1'b0);
            checkOutput($sformatf("requal%0d.rise", k), rise, (k == 6) ? EDGE_EN : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
